vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Parametrised VGA horizontal/vertical timing generator for the VGA controller.
//  Owns the h/v pixel counters. Produces hsync, vsync, video_on, pixel coordinates and frame/line strobes.
//  All sync and region decodes use subtract-and-borrow unsigned compares.
//  Sits between the clock-enable divider and the pixel/colour pipeline.
// PARAMETERS
//  CNT_W     10   counter width; must hold H_TOTAL-1 and V_TOTAL-1 (elaboration error otherwise)
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  SYNC_POL  0    asserted level of hsync/vsync (0 = active-low, 1 = active-high)
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high reset
//  pix_en       in   1      pixel-clock enable; counters advance only on cycles with pix_en=1
//  h_count      out  CNT_W  horizontal counter, 0..H_TOTAL-1
//  v_count      out  CNT_W  vertical counter, 0..V_TOTAL-1
//  pixel_x      out  CNT_W  h_count-(H_SYNC+H_BP) when video_on, else 0
//  pixel_y      out  CNT_W  v_count-(V_SYNC+V_BP) when video_on, else 0
//  hsync        out  1      horizontal sync, level per SYNC_POL
//  vsync        out  1      vertical sync, level per SYNC_POL
//  video_on     out  1      1 inside the active region
//  line_end     out  1      1-clk pulse: h_count just wrapped to 0
//  frame_start  out  1      1-clk pulse: counters just wrapped to (0,0)
// BEHAVIOUR
//  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800). V_TOTAL likewise (525).
//  - Line order: sync, back porch, active, front porch. Sync begins at count 0.
//  - Counting: on pix_en=1, h_count increments. At H_TOTAL-1, h_count wraps to 0 and v_count increments.
//  - v_count wraps to 0 at V_TOTAL-1, but only together with an h_count wrap.
//  - pix_en=0: every output holds. Strobes go to 0.
//  - All outputs are registered and are decoded from the next-count values, so they align exactly with h_count/v_count. No extra latency.
//  - hsync is asserted iff h_count < H_SYNC. vsync is asserted iff v_count < V_SYNC. Asserted level = SYNC_POL.
//  - video_on = (H_SYNC+H_BP <= h_count < H_SYNC+H_BP+H_ACTIVE) AND (V_SYNC+V_BP <= v_count < V_SYNC+V_BP+V_ACTIVE).
//  - Every "<" is an unsigned compare: the borrow out of a CNT_W-bit A + ~B + 1 subtractor.
//  - pixel_x/pixel_y are the subtractor differences, gated to 0 outside video_on.
//  - line_end is 1 for exactly one clk, on the cycle after an advance that wrapped h_count.
//  - frame_start is 1 for exactly one clk, on the cycle after an advance that wrapped both counters. line_end is also 1 on that cycle.
//  - Reset (has priority over pix_en):
//    - h_count, v_count, pixel_x, pixel_y = 0; video_on = 0.
//    - hsync = vsync = SYNC_POL (consistent with count (0,0)).
//    - line_end = frame_start = 0.
//  - Reset mid-frame: the next clk shows (0,0) with no strobe. The first frame_start comes after one full frame.
// STRUCTURE
//  - Package vga_timing_pkg holds the default timing constants, H_TOTAL/V_TOTAL derivation, and a 640x480@60 constant set.
//  - One sub-module: subtrator_nbit, parameter W. Ports A, B, diff, borrow.
//  - Instances: 2 for sync, 4 for region bounds, 2 for pixel_x/y (shared with the lower-bound compares).
//  - Counters, wrap logic and output registers live in vga_sync_gen.
// TESTING
//  1. reset=1 for 3 clk, pix_en=1 -> h=0, v=0, hsync=vsync=0 (SYNC_POL=0), video_on=0, strobes 0.
//  2. Free run, pix_en=1 -> hsync low for exactly 96 clk, then high for 704. Wrap 799->0 increments v. line_end every 800 clk.
//  3. Region check -> video_on=1 only for h 144..783 and v 35..514. pixel_x=0 at h=144 and 639 at h=783. pixel_y=479 at v=514.
//  4. pix_en toggling 1,0,1,0 -> line period 1600 clk. frame_start 1 clk wide, every 840000 clk. Outputs hold when pix_en=0.
//  5. reset pulsed at h=500, v=300 -> next clk h=0, v=0, no frame_start. The next frame_start comes 420000 advances later.
//  6. SYNC_POL=1 with H_SYNC=4, H_ACTIVE=8, V_* small -> hsync high for h 0..3. vsync high for v < V_SYNC. Wrap and strobes still correct.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Timing constants and helpers shared by the VGA sync generator.
// Holds the 640x480@60 set and the line/frame total derivation.
package vga_timing_pkg;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    int unsigned sync;
    int unsigned bp;
    int unsigned active;
    int unsigned fp;
  } axis_timing_t;

  function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  localparam axis_timing_t VGA_640X480_60_H = '{sync: 96, bp: 48, active: 640, fp: 16};
  localparam axis_timing_t VGA_640X480_60_V = '{sync: 2, bp: 33, active: 480, fp: 10};

  localparam int DEF_CNT_W    = 10;
  localparam int DEF_H_SYNC   = int'(VGA_640X480_60_H.sync);
  localparam int DEF_H_BP     = int'(VGA_640X480_60_H.bp);
  localparam int DEF_H_ACTIVE = int'(VGA_640X480_60_H.active);
  localparam int DEF_H_FP     = int'(VGA_640X480_60_H.fp);
  localparam int DEF_V_SYNC   = int'(VGA_640X480_60_V.sync);
  localparam int DEF_V_BP     = int'(VGA_640X480_60_V.bp);
  localparam int DEF_V_ACTIVE = int'(VGA_640X480_60_V.active);
  localparam int DEF_V_FP     = int'(VGA_640X480_60_V.fp);
  localparam bit DEF_SYNC_POL = SYNC_ACTIVE_LOW;

  localparam int H_TOTAL_640X480 = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int V_TOTAL_640X480 = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);

endpackage

// File: rtl/subtrator_nbit.sv
// W-bit A + ~B + 1 subtractor; borrow is 1 exactly when A < B (unsigned).
module subtrator_nbit #(
  parameter int W = 10
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] sum;

  assign sum    = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
  assign diff   = sum[W-1:0];
  assign borrow = ~sum[W];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA h/v timing generator: pixel counters, sync, active-region decode and strobes.
// Decodes run on the next-count values so every registered output lines up with h/v_count.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_start
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;

  // With no front porch the upper bound equals the total and may not fit CNT_W.
  localparam bit H_HI_OPEN = (H_FP == 0);
  localparam bit V_HI_OPEN = (V_FP == 0);

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_width_err
    $error("vga_sync_gen: CNT_W too narrow for H_TOTAL-1");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_width_err
    $error("vga_sync_gen: CNT_W too narrow for V_TOTAL-1");
  end

  localparam int NCMP     = 6;
  localparam int CMP_HS   = 0;
  localparam int CMP_VS   = 1;
  localparam int CMP_HLO  = 2;
  localparam int CMP_HHI  = 3;
  localparam int CMP_VLO  = 4;
  localparam int CMP_VHI  = 5;
  localparam logic [NCMP-1:0] CMP_IS_V = 6'b110010;
  localparam logic [CNT_W-1:0] CMP_B [NCMP] = '{
    CNT_W'(H_SYNC), CNT_W'(V_SYNC), CNT_W'(H_START),
    CNT_W'(H_END), CNT_W'(V_START), CNT_W'(V_END)
  };

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
  logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             line_end_q, line_end_d;
  logic             frame_start_q, frame_start_d;
  logic             h_wrap, v_wrap;

  logic [CNT_W-1:0] cmp_diff [NCMP];
  logic [NCMP-1:0]  cmp_borrow;

  always_comb begin
    h_wrap = pix_en && (h_q == CNT_W'(H_TOTAL - 1));
    v_wrap = h_wrap && (v_q == CNT_W'(V_TOTAL - 1));
    h_d    = h_q;
    v_d    = v_q;
    if (reset) begin
      h_d = '0;
      v_d = '0;
    end else if (pix_en) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end
    end
  end

  // Lower-bound compares double as the pixel_x/pixel_y offset subtractors.
  for (genvar gi = 0; gi < NCMP; gi++) begin : g_cmp
    subtrator_nbit #(.W(CNT_W)) u_sub (
      .A      (CMP_IS_V[gi] ? v_d : h_d),
      .B      (CMP_B[gi]),
      .diff   (cmp_diff[gi]),
      .borrow (cmp_borrow[gi])
    );
  end

  logic unused_diff;
  assign unused_diff = ^{cmp_diff[CMP_HS], cmp_diff[CMP_VS], cmp_diff[CMP_HHI], cmp_diff[CMP_VHI]};

  always_comb begin
    hsync_d       = cmp_borrow[CMP_HS] ? SYNC_POL : ~SYNC_POL;
    vsync_d       = cmp_borrow[CMP_VS] ? SYNC_POL : ~SYNC_POL;
    video_on_d    = ~cmp_borrow[CMP_HLO] & (cmp_borrow[CMP_HHI] | H_HI_OPEN)
                  & ~cmp_borrow[CMP_VLO] & (cmp_borrow[CMP_VHI] | V_HI_OPEN);
    pixel_x_d     = video_on_d ? cmp_diff[CMP_HLO] : '0;
    pixel_y_d     = video_on_d ? cmp_diff[CMP_VLO] : '0;
    line_end_d    = ~reset & h_wrap;
    frame_start_d = ~reset & v_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      hsync_q       <= SYNC_POL;
      vsync_q       <= SYNC_POL;
      video_on_q    <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a 640x480 instance and a tiny active-high-sync instance,
// both checked every cycle against an advance-count arithmetic model.
module tb_vga_sync_gen;

  logic       clk;
  logic       d_reset, d_en, s_reset, s_en;
  logic [9:0] d_h, d_v, d_px, d_py;
  logic       d_hs, d_vs, d_vo, d_le, d_fs;
  logic [4:0] s_h, s_v, s_px, s_py;
  logic       s_hs, s_vs, s_vo, s_le, s_fs;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  longint adv_d = 0, adv_s = 0;
  bit    le_d, fs_d, le_s, fs_s;

  vga_sync_gen dut_def (
    .clk(clk), .reset(d_reset), .pix_en(d_en),
    .h_count(d_h), .v_count(d_v), .pixel_x(d_px), .pixel_y(d_py),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
    .line_end(d_le), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .CNT_W(5), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(3), .SYNC_POL(1'b1)
  ) dut_sml (
    .clk(clk), .reset(s_reset), .pix_en(s_en),
    .h_count(s_h), .v_count(s_v), .pixel_x(s_px), .pixel_y(s_py),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
    .line_end(s_le), .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [44:0] act_d;
  logic [24:0] act_s;
  assign act_d = {d_h, d_v, d_px, d_py, d_hs, d_vs, d_vo, d_le, d_fs};
  assign act_s = {s_h, s_v, s_px, s_py, s_hs, s_vs, s_vo, s_le, s_fs};

  typedef struct {
    int h; int v; int px; int py;
    bit hs; bit vs; bit vo;
  } exp_t;

  // Position follows directly from the number of advances since reset.
  function automatic exp_t model(input longint adv, input int hsw, input int hbp, input int ha,
                                 input int hfp, input int vsw, input int vbp, input int va,
                                 input int vfp, input bit pol);
    exp_t e;
    int ht = hsw + hbp + ha + hfp;
    int vt = vsw + vbp + va + vfp;
    e.h  = int'(adv % longint'(ht));
    e.v  = int'((adv / longint'(ht)) % longint'(vt));
    e.hs = (e.h < hsw) ? pol : !pol;
    e.vs = (e.v < vsw) ? pol : !pol;
    e.vo = (e.h >= hsw + hbp) && (e.h < hsw + hbp + ha) && (e.v >= vsw + vbp) && (e.v < vsw + vbp + va);
    e.px = e.vo ? e.h - (hsw + hbp) : 0;
    e.py = e.vo ? e.v - (vsw + vbp) : 0;
    return e;
  endfunction

  function automatic logic [44:0] exp_vec_d();
    exp_t e = model(adv_d, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0);
    return {10'(e.h), 10'(e.v), 10'(e.px), 10'(e.py), e.hs, e.vs, e.vo, le_d, fs_d};
  endfunction

  function automatic logic [24:0] exp_vec_s();
    exp_t e = model(adv_s, 4, 3, 8, 2, 2, 2, 5, 3, 1'b1);
    return {5'(e.h), 5'(e.v), 5'(e.px), 5'(e.py), e.hs, e.vs, e.vo, le_s, fs_s};
  endfunction

  task automatic tick(input bit rd, input bit ed, input bit rs, input bit es);
    d_reset = rd; d_en = ed; s_reset = rs; s_en = es;
    @(posedge clk);
    if (rd) begin adv_d = 0; le_d = 0; fs_d = 0; end
    else if (ed) begin adv_d++; le_d = (adv_d % 800) == 0; fs_d = (adv_d % 420000) == 0; end
    else begin le_d = 0; fs_d = 0; end
    if (rs) begin adv_s = 0; le_s = 0; fs_s = 0; end
    else if (es) begin adv_s++; le_s = (adv_s % 17) == 0; fs_s = (adv_s % 204) == 0; end
    else begin le_s = 0; fs_s = 0; end
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 1, 1);
      vectors++;
      if (act_d !== exp_vec_d()) begin
        miscompares++;
        $display("FAIL reset_def cyc=%0d got=%h exp=%h", cyc, act_d, exp_vec_d());
      end
      vectors++;
      if (act_s !== exp_vec_s()) begin
        miscompares++;
        $display("FAIL reset_sml cyc=%0d got=%h exp=%h", cyc, act_s, exp_vec_s());
      end
    end
    vectors++;
    if (d_hs !== 1'b0 || d_vs !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sync_level got hs=%b vs=%b exp hs=0 vs=0", d_hs, d_vs);
    end
  endtask

  task automatic test_free_run;
    int last_le = -1;
    int low_cnt = 0;
    int mh, mv;
    for (int i = 0; i < 36 * 800 + 10; i++) begin
      tick(0, 1, 0, 1);
      vectors++;
      if (act_d !== exp_vec_d()) begin
        miscompares++;
        $display("FAIL free_run_def cyc=%0d got=%h exp=%h", cyc, act_d, exp_vec_d());
      end
      vectors++;
      if (act_s !== exp_vec_s()) begin
        miscompares++;
        $display("FAIL free_run_sml cyc=%0d got=%h exp=%h", cyc, act_s, exp_vec_s());
      end
      if (d_le === 1'b1) begin
        if (last_le >= 0) begin
          vectors++;
          if (i - last_le != 800) begin
            miscompares++;
            $display("FAIL line_period got=%0d exp=800", i - last_le);
          end
          vectors++;
          if (low_cnt != 96) begin
            miscompares++;
            $display("FAIL hsync_low_width got=%0d exp=96", low_cnt);
          end
        end
        last_le = i;
        low_cnt = 0;
      end
      if (d_hs === 1'b0) low_cnt++;
      mh = int'(adv_d % 800);
      mv = int'((adv_d / 800) % 525);
      if (mv == 35 && (mh == 143 || mh == 144 || mh == 783 || mh == 784)) begin
        vectors++;
        if (d_vo !== (mh == 144 || mh == 783) || (mh == 144 && d_px !== 10'd0)
            || (mh == 783 && d_px !== 10'd639) || d_py !== 10'd0) begin
          miscompares++;
          $display("FAIL region_edge h=%0d got vo=%b px=%0d py=%0d", mh, d_vo, d_px, d_py);
        end
      end
    end
  endtask

  task automatic test_pix_en_toggle;
    int last_fs = -1;
    for (int i = 0; i < 2 * 204 * 3 + 4; i++) begin
      tick(0, (i % 2) == 0, 0, (i % 2) == 0);
      vectors++;
      if (act_d !== exp_vec_d()) begin
        miscompares++;
        $display("FAIL toggle_def cyc=%0d got=%h exp=%h", cyc, act_d, exp_vec_d());
      end
      vectors++;
      if (act_s !== exp_vec_s()) begin
        miscompares++;
        $display("FAIL toggle_sml cyc=%0d got=%h exp=%h", cyc, act_s, exp_vec_s());
      end
      if (s_fs === 1'b1) begin
        if (last_fs >= 0) begin
          vectors++;
          if (i - last_fs != 408) begin
            miscompares++;
            $display("FAIL frame_period_toggle got=%0d exp=408", i - last_fs);
          end
        end
        last_fs = i;
      end
    end
  endtask

  task automatic test_mid_reset;
    int found = 0;
    int first_fs = -1;
    int first_le = -1;
    for (int i = 0; i < 250 && found == 0; i++) begin
      tick(0, 1, 0, 1);
      if ((adv_s % 17) == 8 && ((adv_s / 17) % 12) == 6) found = 1;
    end
    vectors++;
    if (found == 0) begin
      miscompares++;
      $display("FAIL mid_reset_reach got=h%0d,v%0d exp=h8,v6", s_h, s_v);
    end
    tick(1, 1, 1, 1);
    vectors++;
    if (s_h !== 5'd0 || s_v !== 5'd0 || s_fs !== 1'b0 || s_le !== 1'b0 || act_d !== exp_vec_d()) begin
      miscompares++;
      $display("FAIL mid_reset_zero got h=%0d v=%0d fs=%b le=%b exp 0 0 0 0", s_h, s_v, s_fs, s_le);
    end
    for (int i = 1; i <= 900; i++) begin
      tick(0, 1, 0, 1);
      vectors++;
      if (act_s !== exp_vec_s() || act_d !== exp_vec_d()) begin
        miscompares++;
        $display("FAIL mid_reset_run cyc=%0d got=%h/%h exp=%h/%h", cyc, act_s, act_d, exp_vec_s(), exp_vec_d());
      end
      if (s_fs === 1'b1 && first_fs < 0) first_fs = i;
      if (d_le === 1'b1 && first_le < 0) first_le = i;
    end
    vectors++;
    if (first_fs != 204 || first_le != 800) begin
      miscompares++;
      $display("FAIL first_strobe_after_reset got fs=%0d le=%0d exp fs=204 le=800", first_fs, first_le);
    end
  endtask

  task automatic test_random;
    bit rd, ed, rs, es;
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 299) == 0);
      rs = ($urandom_range(0, 199) == 0);
      ed = ($urandom_range(0, 3) != 0);
      es = ($urandom_range(0, 3) != 0);
      tick(rd, ed, rs, es);
      vectors++;
      if (act_d !== exp_vec_d()) begin
        miscompares++;
        $display("FAIL random_def cyc=%0d got=%h exp=%h", cyc, act_d, exp_vec_d());
      end
      vectors++;
      if (act_s !== exp_vec_s()) begin
        miscompares++;
        $display("FAIL random_sml cyc=%0d got=%h exp=%h", cyc, act_s, exp_vec_s());
      end
    end
  endtask

  initial begin
    d_reset = 1'b1; d_en = 1'b0; s_reset = 1'b1; s_en = 1'b0;
    test_reset();
    test_free_run();
    test_pix_en_toggle();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
